// File: rtl/fetch_entry_fifo_pkg.sv
// Shared types for the fetch entry FIFO: a minimal core configuration,
// the fetch entry record handed from frontend to decode, and the core-level
// default FIFO depth.
package fetch_entry_fifo_pkg;

  typedef struct packed {
    int unsigned XLEN;
    logic        RVC;
    logic        RVH;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{XLEN: 32, RVC: 1'b1, RVH: 1'b0};

  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [2:0]  cf;
    logic [31:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [31:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_fifo.sv
// Elastic buffer between frontend and decode. Circular array of DEPTH
// entries, oldest entry presented on a valid/ready handshake. An accepted
// exception entry blocks further pushes until flush. Flush empties the FIFO
// in the following cycle without clearing storage.
// Optional macro FETCH_ENTRY_FIFO_PERF_EN adds two 32-bit perf counters
// (full-stall cycles and starved cycles).
module fetch_entry_fifo
  import fetch_entry_fifo_pkg::*;
#(
  parameter cfg_t        CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned DEPTH   = FETCH_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  fetch_entry_t           fetch_entry_i,
  input  logic                   fetch_entry_valid_i,
  output logic                   fetch_entry_ready_o,
  output fetch_entry_t           fetch_entry_o,
  output logic                   fetch_entry_valid_o,
  input  logic                   fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0] usage_o,
  output logic                   ex_blocked_o
`ifdef FETCH_ENTRY_FIFO_PERF_EN
  ,
  output logic [31:0]            stall_full_cnt_o,
  output logic [31:0]            starve_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Elaboration guard: pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CVA6Cfg.XLEN == 0) begin : g_bad_cfg
    $error("fetch_entry_fifo: DEPTH must be a power of two >= 2");
  end

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_usage;
  logic          r_ex_blocked;

  logic w_push, w_pop;

  // Ready depends only on state and flush, never on the decode-side ready.
  assign fetch_entry_ready_o = (r_usage < FULL) && !r_ex_blocked && !flush_i;
  assign fetch_entry_valid_o = (r_usage != '0);
  assign fetch_entry_o       = r_mem[r_rd_ptr];
  assign usage_o             = r_usage;
  assign ex_blocked_o        = r_ex_blocked;

  assign w_push = fetch_entry_valid_i && fetch_entry_ready_o;
  assign w_pop  = fetch_entry_valid_o && fetch_entry_ready_i;

  // Storage write; flush never blocks a write since push is already gated by it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= fetch_entry_i;
    end
  end

  // Pointers, occupancy and exception block; flush discards same-cycle pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_usage      <= '0;
      r_ex_blocked <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_usage      <= '0;
      r_ex_blocked <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_usage <= r_usage + CW'(w_push) - CW'(w_pop);
      if (w_push && fetch_entry_i.ex.valid) r_ex_blocked <= 1'b1;
    end
  end

`ifdef FETCH_ENTRY_FIFO_PERF_EN
  logic [31:0] r_stall_full_cnt, r_starve_cnt;

  assign stall_full_cnt_o = r_stall_full_cnt;
  assign starve_cnt_o     = r_starve_cnt;

  // Perf counters: free-running wrap at 2^32, deliberately blind to flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_full_cnt <= '0;
      r_starve_cnt     <= '0;
    end else begin
      if (fetch_entry_valid_i && (r_usage == FULL)) r_stall_full_cnt <= r_stall_full_cnt + 32'd1;
      if ((r_usage == '0) && fetch_entry_ready_i)   r_starve_cnt     <= r_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_entry_fifo.sv
// Directed self-checking bench for fetch_entry_fifo (DEPTH = 4).
module tb_fetch_entry_fifo;
  import fetch_entry_fifo_pkg::*;

  logic         clk, rst_n;
  logic         flush_i;
  fetch_entry_t ent_i, ent_o;
  logic         vld_i, rdy_o, vld_o, rdy_i;
  logic [2:0]   usage;
  logic         ex_blk;
`ifdef FETCH_ENTRY_FIFO_PERF_EN
  logic [31:0]  stall_cnt, starve_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  fetch_entry_fifo #(.DEPTH(4)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush_i),
    .fetch_entry_i       (ent_i),
    .fetch_entry_valid_i (vld_i),
    .fetch_entry_ready_o (rdy_o),
    .fetch_entry_o       (ent_o),
    .fetch_entry_valid_o (vld_o),
    .fetch_entry_ready_i (rdy_i),
    .usage_o             (usage),
    .ex_blocked_o        (ex_blk)
`ifdef FETCH_ENTRY_FIFO_PERF_EN
    ,
    .stall_full_cnt_o    (stall_cnt),
    .starve_cnt_o        (starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] addr, input logic exv);
    fetch_entry_t e;
    e = '0;
    e.address     = addr;
    e.instruction = addr ^ 32'h0000_0013;
    e.ex.valid    = exv;
    e.ex.cause    = exv ? 32'd2 : 32'd0;
    e.ex.tval     = exv ? addr : 32'd0;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; flush_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; ent_i = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; ent_i = '0;
    #2;
    chk("rst_usage", 64'(usage), 64'd0);
    chk("rst_valid", 64'(vld_o), 64'd0);
    chk("rst_exblk", 64'(ex_blk), 64'd0);
    chk("rst_addr",  64'(ent_o.address), 64'd0);
    do_reset();

    // Fill to full with decode stalled, then drain in order.
    rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld_i = 1'b1; ent_i = mk(32'h8000_0000 + 32'(4 * i), 1'b0);
      tick();
      chk("fill_usage", 64'(usage), 64'(i + 1));
    end
    chk("full_ready", 64'(rdy_o), 64'd0);
    chk("full_valid", 64'(vld_o), 64'd1);
    vld_i = 1'b0; rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 64'(ent_o.address), 64'(32'h8000_0000 + 32'(4 * i)));
      tick();
    end
    chk("drain_usage", 64'(usage), 64'd0);
    chk("drain_valid", 64'(vld_o), 64'd0);
    chk("drain_ready", 64'(rdy_o), 64'd1);

    // Streaming: 100 entries, occupancy stays at 1, order kept across wraps.
    rdy_i = 1'b1; vld_i = 1'b1; ent_i = mk(32'h0010_0000, 1'b0);
    tick();
    chk("strm_usage", 64'(usage), 64'd1);
    chk("strm_addr",  64'(ent_o.address), 64'h0010_0000);
    chk("strm_insn",  64'(ent_o.instruction), 64'h0010_0013);
    for (int i = 1; i < 100; i++) begin
      ent_i = mk(32'h0010_0000 + 32'(4 * i), 1'b0);
      tick();
      chk("strm_usage", 64'(usage), 64'd1);
      chk("strm_addr",  64'(ent_o.address), 64'(32'h0010_0000 + 32'(4 * i)));
    end
    vld_i = 1'b0;
    tick();
    chk("strm_end_usage", 64'(usage), 64'd0);
    rdy_i = 1'b0;

    // Exception entry blocks later pushes until flush.
    vld_i = 1'b1; ent_i = mk(32'h0000_1000, 1'b1);
    tick();
    chk("ex_blk_set", 64'(ex_blk), 64'd1);
    chk("ex_ready",   64'(rdy_o), 64'd0);
    chk("ex_addr",    64'(ent_o.address), 64'h1000);
    chk("ex_valid",   64'(ent_o.ex.valid), 64'd1);
    chk("ex_cause",   64'(ent_o.ex.cause), 64'd2);
    ent_i = mk(32'h0000_1004, 1'b0);
    tick(); tick();
    chk("ex_hold_usage", 64'(usage), 64'd1);
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    chk("ex_pop_usage", 64'(usage), 64'd0);
    chk("ex_still_blk", 64'(ex_blk), 64'd1);
    vld_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_ready_comb", 64'(rdy_o), 64'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_exblk", 64'(ex_blk), 64'd0);
    chk("flush_ready", 64'(rdy_o), 64'd1);

    // Flush with simultaneous push and pop at occupancy 3.
    vld_i = 1'b1; rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ent_i = mk(32'h0000_4000 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("pf_usage3", 64'(usage), 64'd3);
    ent_i = mk(32'hDEAD_0000, 1'b0); rdy_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0;
    chk("pf_usage", 64'(usage), 64'd0);
    chk("pf_valid", 64'(vld_o), 64'd0);
    vld_i = 1'b1; ent_i = mk(32'h0000_2000, 1'b0);
    tick();
    vld_i = 1'b0;
    chk("pf_next_addr",  64'(ent_o.address), 64'h2000);
    chk("pf_next_usage", 64'(usage), 64'd1);
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    chk("pf_drain", 64'(usage), 64'd0);

    // Asynchronous reset mid-handshake at occupancy 2.
    vld_i = 1'b1;
    ent_i = mk(32'h0000_5000, 1'b0); tick();
    ent_i = mk(32'h0000_5004, 1'b0); tick();
    chk("ar_usage2", 64'(usage), 64'd2);
    ent_i = mk(32'h0000_5008, 1'b0); rdy_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_usage", 64'(usage), 64'd0);
    chk("ar_valid", 64'(vld_o), 64'd0);
    chk("ar_exblk", 64'(ex_blk), 64'd0);
    chk("ar_addr",  64'(ent_o.address), 64'd0);
    vld_i = 1'b0; rdy_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    vld_i = 1'b1; ent_i = mk(32'h0000_6000, 1'b0);
    tick();
    vld_i = 1'b0;
    chk("ar_first_addr",  64'(ent_o.address), 64'h6000);
    chk("ar_first_usage", 64'(usage), 64'd1);

`ifdef FETCH_ENTRY_FIFO_PERF_EN
    // Perf counters: 10 full-stall cycles, then 5 starved cycles.
    do_reset();
    vld_i = 1'b1; rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ent_i = mk(32'h0000_7000 + 32'(4 * i), 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    vld_i = 1'b0;
    chk("perf_stall", 64'(stall_cnt), 64'd10);
    rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    rdy_i = 1'b0;
    chk("perf_starve", 64'(starve_cnt), 64'd5);
    chk("perf_stall_hold", 64'(stall_cnt), 64'd10);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_entry_fifo.md
Name: fetch_entry_fifo

Overview:
- Elastic buffer between the frontend and the decode stage. Holds up to DEPTH fetch entries and presents the oldest entry to decode over a valid/ready handshake.
- Decouples frontend fetch stalls from decode/issue back-pressure.
- Blocks further fetches after an exception entry until the next flush.
- Clears all contents on a controller flush.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration (widths, RVH/RVC flags).
- DEPTH, 4, number of entry slots; power of two, >= 2.

Ports:
- clk_i  input  1  subsystem clock
- rst_ni  input  1  asynchronous reset, active low
- flush_i  input  1  controller flush; discards all buffered entries
- fetch_entry_i  input  ariane_pkg::fetch_entry_t  entry from frontend (instruction, address, branch_predict, ex)
- fetch_entry_valid_i  input  1  frontend entry valid
- fetch_entry_ready_o  output  1  FIFO accepts entry this cycle
- fetch_entry_o  output  ariane_pkg::fetch_entry_t  oldest buffered entry, to decode
- fetch_entry_valid_o  output  1  fetch_entry_o is valid
- fetch_entry_ready_i  input  1  decode consumes fetch_entry_o this cycle
- usage_o  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- ex_blocked_o  output  1  FIFO holds or has passed an exception entry; pushes blocked

Behaviour:
- Clocking and reset: single clock domain, clk_i. Reset is asynchronous, active low (rst_ni).
- Reset values: storage pointers = 0, usage_o = 0, fetch_entry_valid_o = 0, ex_blocked_o = 0. fetch_entry_o is don't-care while valid is 0; implementation drives '0 after reset.
- Storage: circular array of DEPTH entries.
  - Read pointer, write pointer: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy counter: $clog2(DEPTH)+1 bits.
- push = fetch_entry_valid_i && fetch_entry_ready_o.
- pop = fetch_entry_valid_o && fetch_entry_ready_i.
- fetch_entry_ready_o = (usage < DEPTH) && !ex_blocked_q && !flush_i.
  - Depends only on state and flush_i. No combinational path from fetch_entry_ready_i.
  - When full, a same-cycle pop does not allow a push.
- fetch_entry_valid_o = (usage != 0). fetch_entry_o = storage[rd_ptr], read directly from the array.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 (minimum one cycle, no bypass).
- Simultaneous push and pop: occupancy unchanged, both pointers advance. Legal at any occupancy 1..DEPTH-1.
- Empty: pop impossible because valid = 0.
- Full: ready = 0, so no push.
- Exception blocking: when a pushed entry has ex.valid = 1, ex_blocked_q is set in the next cycle and stays set until flush_i. That entry itself is stored and delivered normally. Later entries are not accepted.
- Flush (flush_i = 1), all applied in the next cycle:
  - Pointers and usage return to 0; ex_blocked_q clears; valid drops.
  - Any push or pop in the flush cycle is discarded.
  - Storage contents are not cleared.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Nothing is retained.
- Order: strictly FIFO. Entries are never reordered or duplicated.

Optional Feature:
- Macro: FETCH_ENTRY_FIFO_PERF_EN.
- When defined, adds two output ports:
  - stall_full_cnt_o (32 bits): counts cycles with fetch_entry_valid_i = 1 and usage = DEPTH.
  - starve_cnt_o (32 bits): counts cycles with usage = 0 and fetch_entry_ready_i = 1.
  - Both counters wrap at 2^32, reset to 0, and are unaffected by flush_i.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Reuse ariane_pkg::fetch_entry_t; no new types are needed for the entry.
- Add to ariane_pkg: localparam FETCH_FIFO_DEPTH = 4 as the core-level default.
- No sub-module: pointer/counter logic and storage stay in one module. The macro-guarded perf counters sit inline.

Test Plan:
- Reset release, then 4 back-to-back pushes (addresses 0x80000000..0x8000000C), ready_i = 0 → usage_o = 4, ready_o = 0 on 5th cycle. Then ready_i = 1 for 4 cycles → addresses delivered in order, usage_o returns to 0, valid_o = 0.
- Continuous streaming, valid_i = 1, ready_i = 1, 100 entries → after 1-cycle fill, one entry out per cycle, usage_o constant 1, order preserved across pointer wrap-around.
- Push entry with ex.valid = 1 at address 0x1000, then keep valid_i = 1 → entry 0x1000 delivered with ex intact, ready_o = 0 and ex_blocked_o = 1 from next cycle. flush_i pulse → ex_blocked_o = 0 and ready_o = 1 the following cycle.
- usage_o = 3 with simultaneous push, pop and flush_i = 1 → next cycle usage_o = 0, valid_o = 0, pushed entry never appears at output.
- rst_ni asserted while usage_o = 2 and mid-handshake → outputs immediately at reset values; after release, first new push is delivered as first output.
- With FETCH_ENTRY_FIFO_PERF_EN: hold full with valid_i = 1 for 10 cycles → stall_full_cnt_o = 10. Empty with ready_i = 1 for 5 cycles → starve_cnt_o = 5.
